// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master bus arbiter with split-transaction sequencing
module bus_arbiter #(
   parameter bit RR_MODE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic breq1,
   input  logic breq2,
   input  logic split_req,
   input  logic split_ready,
   output logic bgrant1,
   output logic bgrant2,
   output logic msel,
   output logic msplit1,
   output logic msplit2,
   output logic split_grant
);

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT1 = 2'd1, GRANT2 = 2'd2} state_t;
   typedef enum logic [1:0] {SO_NONE = 2'd0, SO_M1 = 2'd1, SO_M2 = 2'd2} owner_t;

   state_t state_q, state_d;
   owner_t owner_q, owner_d;
   logic   pend_q, pend_d;
   logic   last_q, last_d;          // 0 = M1 granted last, 1 = M2
   logic   msel_q, msel_d;
   logic   msplit1_q, msplit1_d;
   logic   msplit2_q, msplit2_d;
   logic   sgrant_q, sgrant_d;
   logic   elig1, elig2, cancel, take_m2;

   // Next-state: split bookkeeping first, then the arbitration FSM may override it
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      pend_d    = pend_q;
      last_d    = last_q;
      msel_d    = msel_q;
      msplit1_d = msplit1_q;
      msplit2_d = msplit2_q;
      sgrant_d  = 1'b0;
      take_m2   = 1'b0;

      // A parked master is never eligible until it is resumed or cancels
      elig1  = breq1 && (owner_q != SO_M1);
      elig2  = breq2 && (owner_q != SO_M2);
      cancel = ((owner_q == SO_M1) && !breq1) || ((owner_q == SO_M2) && !breq2);

      if (split_ready && (owner_q != SO_NONE)) begin
         pend_d = 1'b1;
      end

      // Parked master gave up: forget the split entirely
      if (cancel) begin
         owner_d = SO_NONE;
         pend_d  = 1'b0;
         if (owner_q == SO_M1) begin
            msplit1_d = 1'b0;
         end else begin
            msplit2_d = 1'b0;
         end
      end

      case (state_q)
         IDLE: begin
            if (pend_q && !cancel) begin
               // Resume the split master ahead of any fresh request
               sgrant_d = 1'b1;
               owner_d  = SO_NONE;
               pend_d   = 1'b0;
               if (owner_q == SO_M2) begin
                  state_d   = GRANT2;
                  msplit2_d = 1'b0;
                  last_d    = 1'b1;
                  msel_d    = 1'b1;
               end else begin
                  state_d   = GRANT1;
                  msplit1_d = 1'b0;
                  last_d    = 1'b0;
                  msel_d    = 1'b0;
               end
            end else if (elig1 || elig2) begin
               if (elig1 && elig2) begin
                  take_m2 = (RR_MODE == 1'b1) ? !last_q : 1'b0;
               end else begin
                  take_m2 = elig2;
               end
               state_d = take_m2 ? GRANT2 : GRANT1;
               last_d  = take_m2;
               msel_d  = take_m2;
            end
         end
         GRANT1: begin
            if (!breq1) begin
               state_d = IDLE;
            end else if (split_req && (owner_q == SO_NONE)) begin
               owner_d   = SO_M1;
               msplit1_d = 1'b1;
               state_d   = IDLE;
            end
         end
         GRANT2: begin
            if (!breq2) begin
               state_d = IDLE;
            end else if (split_req && (owner_q == SO_NONE)) begin
               owner_d   = SO_M2;
               msplit2_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and all outputs register together so grants follow the state edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= SO_NONE;
         pend_q    <= 1'b0;
         last_q    <= 1'b1;
         msel_q    <= 1'b0;
         msplit1_q <= 1'b0;
         msplit2_q <= 1'b0;
         sgrant_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         pend_q    <= pend_d;
         last_q    <= last_d;
         msel_q    <= msel_d;
         msplit1_q <= msplit1_d;
         msplit2_q <= msplit2_d;
         sgrant_q  <= sgrant_d;
      end
   end

   assign bgrant1     = (state_q == GRANT1);
   assign bgrant2     = (state_q == GRANT2);
   assign msel        = msel_q;
   assign msplit1     = msplit1_q;
   assign msplit2     = msplit2_q;
   assign split_grant = sgrant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter in both arbitration modes
module tb_bus_arbiter;

   logic clk, rst, breq1, breq2, split_req, split_ready;
   logic g1_0, g2_0, msel_0, ms1_0, ms2_0, sg_0;
   logic g1_1, g2_1, msel_1, ms1_1, ms2_1, sg_1;
   logic [5:0] out0, out1;

   // expected vectors are {bgrant1, bgrant2, msel, msplit1, msplit2, split_grant}
   typedef struct {
      logic [5:0] e0;
      logic [5:0] e1;
      string      nm;
   } item_t;

   item_t q[$];
   int    checks = 0;
   int    errors = 0;
   bit    done = 1'b0;

   bus_arbiter #(.RR_MODE(1'b0)) u0 (
      .clk(clk), .rst(rst), .breq1(breq1), .breq2(breq2),
      .split_req(split_req), .split_ready(split_ready),
      .bgrant1(g1_0), .bgrant2(g2_0), .msel(msel_0),
      .msplit1(ms1_0), .msplit2(ms2_0), .split_grant(sg_0)
   );

   bus_arbiter #(.RR_MODE(1'b1)) u1 (
      .clk(clk), .rst(rst), .breq1(breq1), .breq2(breq2),
      .split_req(split_req), .split_ready(split_ready),
      .bgrant1(g1_1), .bgrant2(g2_1), .msel(msel_1),
      .msplit1(ms1_1), .msplit2(ms2_1), .split_grant(sg_1)
   );

   assign out0 = {g1_0, g2_0, msel_0, ms1_0, ms2_0, sg_0};
   assign out1 = {g1_1, g2_1, msel_1, ms1_1, ms2_1, sg_1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input logic [5:0] x0, input logic [5:0] x1, input string nm);
      item_t it;
      it.e0 = x0;
      it.e1 = x1;
      it.nm = nm;
      q.push_back(it);
   endtask

   // one bus cycle: inputs applied after a falling edge, result checked at the next one
   task automatic step(input logic b1, input logic b2, input logic sq, input logic sr,
                       input logic [5:0] x0, input logic [5:0] x1, input string nm);
      @(negedge clk);
      #1;
      rst         = 1'b0;
      breq1       = b1;
      breq2       = b2;
      split_req   = sq;
      split_ready = sr;
      push(x0, x1, nm);
   endtask

   task automatic do_reset(input logic b1, input logic b2, input string nm);
      @(negedge clk);
      #1;
      rst         = 1'b1;
      breq1       = b1;
      breq2       = b2;
      split_req   = 1'b0;
      split_ready = 1'b0;
      push(6'b000000, 6'b000000, nm);
   endtask

   // reset raised just after a rising edge and checked before the next one
   task automatic async_reset(input string nm);
      @(negedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      push(6'b000000, 6'b000000, nm);
   endtask

   // stimulus
   initial begin
      rst = 1'b1; breq1 = 1'b0; breq2 = 1'b0; split_req = 1'b0; split_ready = 1'b0;

      do_reset(1'b1, 1'b1, "reset_both_req");
      step(1, 1, 0, 0, 6'b100000, 6'b100000, "first_grant");
      for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 6'b100000, 6'b100000, "hold_m1");
      step(0, 1, 0, 0, 6'b000000, 6'b000000, "m1_release");
      step(1, 1, 0, 0, 6'b100000, 6'b011000, "tie_after_gap");
      step(1, 1, 0, 0, 6'b100000, 6'b011000, "tie_hold");
      step(1, 0, 0, 0, 6'b100000, 6'b001000, "m2_release");
      step(1, 1, 0, 0, 6'b100000, 6'b100000, "rr_back_m1");
      step(0, 1, 0, 0, 6'b000000, 6'b000000, "m1_release2");
      step(1, 1, 0, 0, 6'b100000, 6'b011000, "starve_vs_rr");

      do_reset(1, 0, "reset_split");
      step(1, 0, 0, 0, 6'b100000, 6'b100000, "m1_grant");
      step(1, 1, 1, 0, 6'b000100, 6'b000100, "split_m1");
      step(1, 1, 0, 0, 6'b011100, 6'b011100, "m2_after_split");
      step(1, 1, 0, 1, 6'b011100, 6'b011100, "ready_during_m2");
      step(1, 1, 0, 0, 6'b011100, 6'b011100, "ready_wait");
      step(1, 1, 1, 0, 6'b011100, 6'b011100, "second_split_ign");
      step(1, 0, 0, 0, 6'b001100, 6'b001100, "m2_release_split");
      step(1, 0, 0, 0, 6'b100001, 6'b100001, "resume_m1");
      step(1, 0, 0, 0, 6'b100000, 6'b100000, "sgrant_one_pulse");
      step(1, 0, 0, 1, 6'b100000, 6'b100000, "ready_no_split");
      step(0, 0, 0, 0, 6'b000000, 6'b000000, "m1_release3");
      step(0, 0, 0, 0, 6'b000000, 6'b000000, "no_stray_resume");

      step(0, 1, 0, 0, 6'b011000, 6'b011000, "m2_grant");
      step(0, 1, 1, 0, 6'b001010, 6'b001010, "split_m2");
      step(0, 1, 0, 0, 6'b001010, 6'b001010, "m2_parked");
      step(0, 0, 0, 0, 6'b001000, 6'b001000, "split_cancel");
      step(0, 0, 0, 1, 6'b001000, 6'b001000, "ready_after_cancel");
      step(0, 0, 0, 0, 6'b001000, 6'b001000, "no_grant_after_cancel");
      step(0, 1, 0, 0, 6'b011000, 6'b011000, "m2_regrant");
      step(0, 0, 1, 0, 6'b001000, 6'b001000, "release_beats_split");
      step(0, 1, 0, 0, 6'b011000, 6'b011000, "m2_not_parked");

      async_reset("async_rst_grant");
      step(0, 1, 0, 0, 6'b011000, 6'b011000, "grant_after_rst");
      step(0, 1, 1, 0, 6'b001010, 6'b001010, "split_before_rst");
      async_reset("async_rst_split");
      step(0, 1, 0, 0, 6'b011000, 6'b011000, "split_discarded");
      done = 1'b1;
   end

   // monitor: pops one expectation per cycle and compares both instances
   initial begin
      item_t it;
      int guard;
      guard = 0;
      while (!(done && (q.size() == 0)) && (guard < 5000)) begin
         @(negedge clk);
         guard++;
         if (q.size() > 0) begin
            it = q.pop_front();
            checks++;
            if (out0 !== it.e0) begin
               errors++;
               $display("FAIL %s rr0 got %b want %b", it.nm, out0, it.e0);
            end
            checks++;
            if (out1 !== it.e1) begin
               errors++;
               $display("FAIL %s rr1 got %b want %b", it.nm, out1, it.e1);
            end
         end
      end
      checks++;
      if (!done || (q.size() != 0)) begin
         errors++;
         $display("FAIL timeout done %0d pending %0d want done 1 pending 0", done, q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
